// File: rtl/crossbar_row_loader.sv
// Upstream feeder for the crossbar row registers: packs W-bit host chunks into
// N-bit rows and strobes them one-hot into consecutive rows per start command.
module crossbar_row_loader #(
   parameter int N = 10,
   parameter int W = 4,
   parameter int R = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [$clog2(R+1)-1:0]   row_count,
   input  logic                     in_valid,
   input  logic [W-1:0]             in_data,
   output logic                     in_ready,
   output logic [N-1:0]             row_data,
   output logic [R-1:0]             row_load,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               state_dbg
);

   localparam int CHUNKS = (N + W - 1) / W;
   localparam int BW     = CHUNKS * W;
   localparam int CCW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int RIW    = $clog2(R);
   localparam int CNTW   = $clog2(R + 1);

   // Handshake: a chunk transfers on a rising edge where in_valid & in_ready are both high;
   // in_ready is high exactly while COLLECT is active.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      LOAD    = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t            state_q;
   logic [CNTW-1:0]   count_q;
   logic [RIW-1:0]    row_q;
   logic [CCW-1:0]    chunk_q;
   logic [BW-1:0]     buf_q;
   logic [N-1:0]      row_data_q;
   logic [R-1:0]      row_load_q;
   logic              in_ready_q;
   logic              busy_q;
   logic              done_q;

   logic [BW-1:0]     asm_d;
   logic [CNTW-1:0]   count_d;
   logic              last_chunk;
   logic              last_row;
   logic              hs;

   always_comb begin
      asm_d = buf_q;
      asm_d[int'(chunk_q)*W +: W] = in_data;
   end

   assign count_d    = (row_count > CNTW'(R)) ? CNTW'(R) : row_count;
   assign last_chunk = (chunk_q == CCW'(CHUNKS - 1));
   assign last_row   = (CNTW'(row_q) == (count_q - CNTW'(1)));
   assign hs         = in_valid & in_ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         row_q      <= '0;
         chunk_q    <= '0;
         buf_q      <= '0;
         row_data_q <= '0;
         row_load_q <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         row_load_q <= '0;
         done_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (row_count == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     count_q    <= count_d;
                     row_q      <= '0;
                     chunk_q    <= '0;
                     buf_q      <= '0;
                     in_ready_q <= 1'b1;
                     state_q    <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               if (hs) begin
                  if (last_chunk) begin
                     // Pad bits above N-1 in the final chunk are dropped here.
                     row_data_q        <= asm_d[N-1:0];
                     buf_q             <= '0;
                     chunk_q           <= '0;
                     in_ready_q        <= 1'b0;
                     row_load_q[row_q] <= 1'b1;
                     state_q           <= LOAD;
                  end else begin
                     buf_q   <= asm_d;
                     chunk_q <= chunk_q + CCW'(1);
                  end
               end
            end
            LOAD: begin
               if (last_row) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  row_q      <= row_q + RIW'(1);
                  chunk_q    <= '0;
                  in_ready_q <= 1'b1;
                  state_q    <= COLLECT;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign row_data  = row_data_q;
   assign row_load  = row_load_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_crossbar_row_loader.sv
// Self-checking bench for crossbar_row_loader: table-driven commands, hand-written
// corner sequences and randomized commands against a row-level reference model.
module tb_crossbar_row_loader;

   localparam int N      = 10;
   localparam int W      = 4;
   localparam int R      = 8;
   localparam int CHUNKS = (N + W - 1) / W;
   localparam int CNTW   = $clog2(R + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [CNTW-1:0] row_count;
   logic            in_valid;
   logic [W-1:0]    in_data;
   logic            in_ready;
   logic [N-1:0]    row_data;
   logic [R-1:0]    row_load;
   logic            busy;
   logic            done;
   logic [1:0]      state_dbg;

   crossbar_row_loader #(.N(N), .W(W), .R(R)) dut (
      .clk(clk), .rst(rst), .start(start), .row_count(row_count),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .row_data(row_data), .row_load(row_load), .busy(busy), .done(done),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int load_cnt = 0;
   int done_cnt = 0;
   int cyc      = 0;
   int last_load_cyc = -1;
   bit spacing_on = 1'b0;
   bit prev_hs    = 1'b0;

   logic [R+N-1:0] exp_q[$];
   logic [N-1:0]   row_vals[R+2];

   typedef struct {
      int           cnt;
      logic [N-1:0] r0;
      logic [N-1:0] r1;
      logic [N-1:0] r2;
      int           gap;
      int           exp_loads;
   } vec_t;

   vec_t tab[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Scoreboard / protocol monitor, sampling mid-cycle.
   always @(negedge clk) begin
      logic [R+N-1:0] e;
      cyc++;
      if (!rst) begin
         if (row_load != '0) begin
            load_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_row_load", 32'(row_load), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("row_load", 32'(row_load), 32'(e[R+N-1:N]));
               chk("row_data", 32'(row_data), 32'(e[N-1:0]));
            end
            chk("in_ready_in_load", 32'(in_ready), 32'd0);
            chk("load_after_last_hs", 32'(prev_hs), 32'd1);
            if (spacing_on && last_load_cyc >= 0)
               chk("load_spacing", 32'(cyc - last_load_cyc), 32'(CHUNKS + 1));
            last_load_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
            chk("busy_in_done", 32'(busy), 32'd1);
         end
         if (busy && !done && row_load == '0 && !in_valid)
            chk("in_ready_stall", 32'(in_ready), 32'd1);
      end
      prev_hs = in_valid & in_ready;
   end

   task automatic send_chunk(input logic [W-1:0] d, input int gap, output bit ok);
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = d;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic push_exp(input int idx, input logic [N-1:0] val);
      logic [R-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      exp_q.push_back({oh, val});
   endtask

   task automatic send_row(input logic [N-1:0] val, input int gap_fixed, input int gap_max,
                           input bit rand_pad, output bit ok);
      logic [CHUNKS*W-1:0] padded;
      padded = rand_pad ? (CHUNKS*W)'($urandom) : '1;
      padded[N-1:0] = val;
      ok = 1'b1;
      for (int k = 0; k < CHUNKS && ok; k++)
         send_chunk(padded[k*W +: W], (k == 2 ? gap_fixed : 0) + $urandom_range(0, gap_max), ok);
      if (!ok) chk("chunk_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_cmd(input int cnt, input int gap_fixed, input int gap_max,
                          input int spurious, input bit rand_pad, input int exp_loads);
      int  n;
      int  l0;
      int  d0;
      bit  ok;
      bit  seen;
      n  = (cnt > R) ? R : cnt;
      l0 = load_cnt;
      d0 = done_cnt;
      last_load_cyc = -1;
      spacing_on = (gap_fixed == 0 && gap_max == 0 && spurious == 0);
      for (int i = 0; i < n; i++) push_exp(i, row_vals[i]);
      start = 1'b1;
      row_count = CNTW'(cnt);
      @(posedge clk); #1;
      start = 1'b0;
      ok = 1'b1;
      for (int r = 0; r < n && ok; r++) begin
         if (r == 1 && spurious != 0) begin
            start = 1'b1;
            row_count = CNTW'(spurious);
            @(posedge clk); #1;
            start = 1'b0;
         end
         send_row(row_vals[r], gap_fixed, gap_max, rand_pad, ok);
      end
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      chk("load_count", 32'(load_cnt - l0), 32'(exp_loads));
      chk("done_count", 32'(done_cnt - d0), 32'd1);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("idle_after_done", {busy, state_dbg}, 32'd0);
      exp_q.delete();
   endtask

   initial begin
      bit ok;
      rst = 1'b1; start = 1'b0; row_count = '0; in_valid = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {in_ready, row_data, row_load, busy, done}, 32'd0);
      chk("reset_state", 32'(state_dbg), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      tab[0] = '{cnt: 1, r0: 10'h35A, r1: 10'h000, r2: 10'h000, gap: 0, exp_loads: 1};
      tab[1] = '{cnt: 3, r0: 10'h001, r1: 10'h2AA, r2: 10'h3FF, gap: 0, exp_loads: 3};
      tab[2] = '{cnt: 1, r0: 10'h1E4, r1: 10'h000, r2: 10'h000, gap: 5, exp_loads: 1};
      tab[3] = '{cnt: 0, r0: 10'h000, r1: 10'h000, r2: 10'h000, gap: 0, exp_loads: 0};
      tab[4] = '{cnt: 9, r0: 10'h3C3, r1: 10'h0F0, r2: 10'h155, gap: 0, exp_loads: 8};
      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < R + 2; i++) row_vals[i] = N'($urandom);
         row_vals[0] = tab[t].r0;
         row_vals[1] = tab[t].r1;
         row_vals[2] = tab[t].r2;
         run_cmd(tab[t].cnt, tab[t].gap, 0, 0, 1'b0, tab[t].exp_loads);
      end

      // Second start mid-command must be ignored: only the original 2 rows load.
      row_vals[0] = 10'h2D1;
      row_vals[1] = 10'h10E;
      run_cmd(2, 0, 0, 5, 1'b1, 2);

      // Reset during COLLECT of row 1 of 3 aborts cleanly.
      begin
         int d0;
         d0 = done_cnt;
         push_exp(0, 10'h155);
         start = 1'b1; row_count = CNTW'(3);
         @(posedge clk); #1;
         start = 1'b0;
         send_row(10'h155, 0, 0, 1'b0, ok);
         send_chunk(4'hF, 0, ok);
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         @(negedge clk);
         chk("abort_outputs", {in_ready, row_data, row_load, busy, done}, 32'd0);
         chk("abort_state", 32'(state_dbg), 32'd0);
         exp_q.delete();
         repeat (3) @(negedge clk);
         chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
         @(posedge clk); #1;
         row_vals[0] = 10'h0C3;
         run_cmd(1, 0, 0, 0, 1'b0, 1);
      end

      // Randomized commands with random gaps and pad bits.
      for (int t = 0; t < 8; t++) begin
         int c;
         c = $urandom_range(0, R + 1);
         for (int i = 0; i < R + 2; i++) row_vals[i] = N'($urandom);
         run_cmd(c, 0, $urandom_range(0, 2), 0, 1'b1, (c > R) ? R : c);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1);
   end

endmodule
